// File: rtl/dm_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter.
//   state_t : arbiter FSM states (IDLE, ISSUE, WAIT, ACK)
//   AW_DEF  : default word-address width (byte address bits [31:2])
//   DW_DEF  : default data width
package dm_arb_pkg;

  localparam int unsigned AW_DEF = 30;
  localparam int unsigned DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick.
//   req0, req1 : request lines
//   last       : index of the port granted most recently
//   grant_c    : at least one port is requesting
//   winner_c   : index of the port that wins this round
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant_c,
  output logic winner_c
);

  // On a tie the port that did not win last time goes next.
  always_comb begin
    grant_c  = req0 | req1;
    winner_c = (req0 & req1) ? ~last : req1;
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-requester arbiter in front of a single-port data memory with a
// one-edge registered read. Every access takes a fixed four-cycle slot:
// grant (IDLE) -> ISSUE -> WAIT -> ACK.
//   Clk, Reset            : clock, async active-low reset
//   Req/We/Ad/WrData{0,1} : requester command inputs
//   Ack{0,1}              : one-cycle completion pulse per requester
//   RdData{0,1}           : last read result per requester
//   Ad, WrData, MemWr, DM : data-memory interface
//   Busy                  : FSM is outside IDLE
//   Owner                 : port of the current or last transaction
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Req0,
  input  logic          We0,
  input  logic [AW-1:0] Ad0,
  input  logic [DW-1:0] WrData0,
  input  logic          Req1,
  input  logic          We1,
  input  logic [AW-1:0] Ad1,
  input  logic [DW-1:0] WrData1,
  output logic          Ack0,
  output logic          Ack1,
  output logic [DW-1:0] RdData0,
  output logic [DW-1:0] RdData1,
  output logic [AW-1:0] Ad,
  output logic [DW-1:0] WrData,
  output logic          MemWr,
  input  logic [DW-1:0] DM,
  output logic          Busy,
  output logic          Owner
);

  state_t state, next_state;

  logic last;
  logic op_we;
  logic grant_c;
  logic winner_c;

  logic [AW-1:0] ad_d;
  logic [DW-1:0] wrdata_d;
  logic          memwr_d;
  logic          owner_d;
  logic          last_d;
  logic          op_we_d;
  logic          ack0_d;
  logic          ack1_d;
  logic [DW-1:0] rd0_d;
  logic [DW-1:0] rd1_d;
  logic          busy_d;

  rr_arb2 u_rr (
    .req0     (Req0),
    .req1     (Req1),
    .last     (last),
    .grant_c  (grant_c),
    .winner_c (winner_c)
  );

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: fixed four-cycle slot once a request is granted.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant_c) next_state = ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT:    next_state = ACK;
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output/datapath next values; MemWr is only ever raised for ISSUE.
  always_comb begin
    ad_d     = Ad;
    wrdata_d = WrData;
    memwr_d  = 1'b0;
    owner_d  = Owner;
    last_d   = last;
    op_we_d  = op_we;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rd0_d    = RdData0;
    rd1_d    = RdData1;
    busy_d   = (next_state != IDLE);
    case (state)
      IDLE: begin
        if (grant_c) begin
          ad_d     = winner_c ? Ad1 : Ad0;
          wrdata_d = winner_c ? WrData1 : WrData0;
          memwr_d  = winner_c ? We1 : We0;
          op_we_d  = winner_c ? We1 : We0;
          owner_d  = winner_c;
          last_d   = winner_c;
        end
      end
      WAIT: begin
        // DM now holds the word sampled at the ISSUE edge.
        if (!op_we) begin
          if (Owner) rd1_d = DM;
          else       rd0_d = DM;
        end
        ack0_d = ~Owner;
        ack1_d = Owner;
      end
      default: begin
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Ad      <= '0;
      WrData  <= '0;
      MemWr   <= 1'b0;
      Owner   <= 1'b0;
      last    <= 1'b1;
      op_we   <= 1'b0;
      Ack0    <= 1'b0;
      Ack1    <= 1'b0;
      RdData0 <= '0;
      RdData1 <= '0;
      Busy    <= 1'b0;
    end else begin
      Ad      <= ad_d;
      WrData  <= wrdata_d;
      MemWr   <= memwr_d;
      Owner   <= owner_d;
      last    <= last_d;
      op_we   <= op_we_d;
      Ack0    <= ack0_d;
      Ack1    <= ack1_d;
      RdData0 <= rd0_d;
      RdData1 <= rd1_d;
      Busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Randomised and directed bench for dm_arbiter with a transaction-level
// reference model feeding a scoreboard queue and an independent monitor.
module tb_dm_arbiter;

  localparam int unsigned AW = 30;
  localparam int unsigned DW = 32;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          req [2];
  logic          we  [2];
  logic [AW-1:0] ad  [2];
  logic [DW-1:0] wd  [2];
  logic          ack [2];
  logic [DW-1:0] rd  [2];
  logic [AW-1:0] Ad;
  logic [DW-1:0] WrData;
  logic          MemWr;
  logic [DW-1:0] DM = '0;
  logic          Busy;
  logic          Owner;

  int n_vec = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  dm_arbiter #(.AW(AW), .DW(DW)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req0(req[0]), .We0(we[0]), .Ad0(ad[0]), .WrData0(wd[0]),
    .Req1(req[1]), .We1(we[1]), .Ad1(ad[1]), .WrData1(wd[1]),
    .Ack0(ack[0]), .Ack1(ack[1]), .RdData0(rd[0]), .RdData1(rd[1]),
    .Ad(Ad), .WrData(WrData), .MemWr(MemWr), .DM(DM),
    .Busy(Busy), .Owner(Owner)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: 32 words, read data registered one edge after Ad.
  logic          load;
  logic [DW-1:0] mem     [32];
  logic [DW-1:0] ref_mem [32];

  always @(posedge Clk) begin
    if (load) begin
      for (int i = 0; i < 32; i++) mem[i] <= ref_mem[i];
    end else if (MemWr) begin
      mem[Ad[4:0]] <= WrData;
    end
    DM <= mem[Ad[4:0]];
  end

  // Reference model: one access per four-cycle slot, round-robin on ties.
  typedef struct packed {
    logic          port;
    logic          we;
    logic [DW-1:0] rd;
  } txn_t;

  txn_t          sb [$];
  int            m_phase;
  logic          m_last;
  logic          m_owner;
  logic          m_we;
  logic          m_win;
  txn_t          tn;
  logic [DW-1:0] exp_rd [2];

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_phase   = 0;
      m_last    = 1'b1;
      m_owner   = 1'b0;
      m_we      = 1'b0;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      sb.delete();
    end else if (m_phase == 0) begin
      if (req[0] || req[1]) begin
        m_win   = (req[0] && req[1]) ? !m_last : req[1];
        m_last  = m_win;
        m_owner = m_win;
        m_we    = we[m_win];
        tn.port = m_win;
        tn.we   = we[m_win];
        if (we[m_win]) begin
          ref_mem[ad[m_win][4:0]] = wd[m_win];
          tn.rd = '0;
        end else begin
          tn.rd = ref_mem[ad[m_win][4:0]];
        end
        sb.push_back(tn);
        m_phase = 1;
      end
    end else begin
      m_phase = (m_phase + 1) % 4;
    end
  end

  // Monitor: pops the scoreboard on every Ack and checks the interface.
  txn_t got;
  always @(negedge Clk) begin
    if (!Reset) begin
      chk("rst_ack0", ack[0], 0);
      chk("rst_ack1", ack[1], 0);
      chk("rst_memwr", MemWr, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_owner", Owner, 0);
      chk("rst_ad", Ad, 0);
      chk("rst_wrdata", WrData, 0);
      chk("rst_rd0", rd[0], 0);
      chk("rst_rd1", rd[1], 0);
    end else begin
      chk("ack_overlap", ack[0] & ack[1], 0);
      chk("busy", Busy, m_phase != 0);
      chk("memwr", MemWr, (m_phase == 1) && m_we);
      chk("owner", Owner, m_owner);
      chk("ack_timing", ack[0] | ack[1], m_phase == 3);
      if (ack[0] || ack[1] || m_phase == 3) begin
        chk("ack_has_expect", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          got = sb.pop_front();
          if (ack[0] || ack[1]) chk("ack_port", ack[1], got.port);
          if (!got.we) exp_rd[got.port] = got.rd;
        end
      end
      chk("rddata0", rd[0], exp_rd[0]);
      chk("rddata1", rd[1], exp_rd[1]);
    end
  end

  // Waits up to 12 cycles for Ack on port p; lat = cycles waited.
  task automatic wait_ack(input int p, output int lat);
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge Clk);
      if (ack[p]) begin
        lat = i;
        break;
      end
    end
    chk("ack_seen", lat > 0, 1);
  endtask

  task automatic txn(input int p, input logic w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, output logic [DW-1:0] r, output int lat);
    @(negedge Clk);
    req[p] = 1'b1; we[p] = w; ad[p] = a; wd[p] = d;
    wait_ack(p, lat);
    r = rd[p];
    req[p] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int            order [$];
  int            exp_order [6];
  int            cnt [2];
  int            lat;
  logic [DW-1:0] r;

  initial begin
    Reset = 1'b0;
    load  = 1'b1;
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; we[p] = 1'b0; ad[p] = '0; wd[p] = '0;
    end
    for (int i = 0; i < 32; i++) ref_mem[i] = $urandom;
    ref_mem[4] = 32'hDEADBEEF;
    repeat (3) @(negedge Clk);
    load  = 1'b0;
    Reset = 1'b1;

    // Contention straight after reset: grants alternate starting at port 0.
    exp_order = '{0, 1, 0, 1, 0, 1};
    cnt[0] = 0; cnt[1] = 0;
    @(negedge Clk);
    req[0] = 1'b1; we[0] = 1'b0; ad[0] = AW'(1);
    req[1] = 1'b1; we[1] = 1'b0; ad[1] = AW'(2);
    for (int i = 0; i < 60 && order.size() < 6; i++) begin
      @(negedge Clk);
      for (int p = 0; p < 2; p++) begin
        if (ack[p]) begin
          order.push_back(p);
          cnt[p]++;
          if (cnt[p] == 3) req[p] = 1'b0;
        end
      end
    end
    req[0] = 1'b0; req[1] = 1'b0;
    chk("contention_count", order.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < order.size()) chk("contention_order", order[i], exp_order[i]);
    end

    // Single read with fixed latency.
    txn(0, 1'b0, AW'(4), '0, r, lat);
    chk("single_read_lat", lat, 3);
    chk("single_read_data", r, 32'hDEADBEEF);

    // Write then read on port 1.
    txn(1, 1'b1, AW'(16), 32'h12345678, r, lat);
    chk("write_lat", lat, 3);
    txn(1, 1'b0, AW'(16), '0, r, lat);
    chk("write_read_data", r, 32'h12345678);

    // Command fields changed after grant must not affect the access.
    @(negedge Clk);
    req[0] = 1'b1; we[0] = 1'b0; ad[0] = AW'(4);
    @(negedge Clk);
    we[0] = 1'b1; ad[0] = AW'(7); wd[0] = 32'h0BAD0BAD;
    wait_ack(0, lat);
    req[0] = 1'b0;
    chk("late_change_lat", lat, 2);
    chk("late_change_data", rd[0], 32'hDEADBEEF);

    // Early drop: one-cycle request still completes, nothing follows.
    @(negedge Clk);
    req[1] = 1'b1; we[1] = 1'b0; ad[1] = AW'(3);
    @(negedge Clk);
    req[1] = 1'b0;
    wait_ack(1, lat);
    chk("early_drop_lat", lat, 2);
    repeat (6) @(negedge Clk);
    chk("early_drop_idle", Busy, 0);

    // Reset during WAIT of a port-0 read.
    @(negedge Clk);
    req[0] = 1'b1; we[0] = 1'b0; ad[0] = AW'(4);
    @(negedge Clk);
    @(negedge Clk);
    #2;
    Reset = 1'b0;
    req[0] = 1'b0;
    chk("mid_reset_memwr", MemWr, 0);
    repeat (3) @(negedge Clk);
    #2;
    Reset = 1'b1;
    @(negedge Clk);
    req[0] = 1'b1; we[0] = 1'b0; ad[0] = AW'(5);
    req[1] = 1'b1; we[1] = 1'b0; ad[1] = AW'(6);
    wait_ack(0, lat);
    chk("tie_after_reset_lat", lat, 3);
    chk("tie_after_reset_ack1", ack[1], 0);
    req[0] = 1'b0;
    wait_ack(1, lat);
    req[1] = 1'b0;

    // Randomised traffic with early drops, late field changes and back-to-back.
    for (int c = 0; c < 600; c++) begin
      @(negedge Clk);
      for (int p = 0; p < 2; p++) begin
        if (!req[p]) begin
          if ($urandom_range(0, 99) < 40) begin
            req[p] = 1'b1;
            we[p]  = 1'($urandom_range(0, 1));
            ad[p]  = AW'($urandom_range(0, 31));
            wd[p]  = $urandom;
          end
        end else if (ack[p]) begin
          if ($urandom_range(0, 1) == 0) begin
            req[p] = 1'b0;
          end else begin
            we[p] = 1'($urandom_range(0, 1));
            ad[p] = AW'($urandom_range(0, 31));
            wd[p] = $urandom;
          end
        end else begin
          lat = int'($urandom_range(0, 99));
          if (lat < 5) begin
            req[p] = 1'b0;
          end else if (lat < 15) begin
            we[p] = 1'($urandom_range(0, 1));
            ad[p] = AW'($urandom_range(0, 31));
            wd[p] = $urandom;
          end
        end
      end
    end
    req[0] = 1'b0; req[1] = 1'b0;
    repeat (8) @(negedge Clk);
    chk("drain_scoreboard", sb.size(), 0);
    chk("drain_busy", Busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter AW, default 30, word-address width (byte address bits [31:2]).
REQ-002 Parameter DW, default 32, data width.
REQ-003 Clk  input  1  single clock; all state changes on posedge Clk.
REQ-004 Reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 ReqN (N=0,1)  input  1  requester N access request; held high until AckN.
REQ-006 WeN (N=0,1)  input  1  1 = write, 0 = read; valid while ReqN high.
REQ-007 AdN (N=0,1)  input  AW  word address [31:2]; valid while ReqN high.
REQ-008 WrDataN (N=0,1)  input  DW  write data; valid while ReqN and WeN high.
REQ-009 AckN (N=0,1)  output  1  one-cycle completion pulse to requester N.
REQ-010 RdDataN (N=0,1)  output  DW  read result; valid in the AckN cycle of a read, held until the next read for port N completes.
REQ-011 Ad  output  AW  word address to the data memory.
REQ-012 WrData  output  DW  write data to the data memory.
REQ-013 MemWr  output  1  memory write enable.
REQ-014 DM  input  DW  memory read data; registered by the memory one edge after Ad is sampled with MemWr=0.
REQ-015 Busy  output  1  high in every state except IDLE.
REQ-016 Owner  output  1  index of the port granted for the current or last transaction.

Function
REQ-017 FSM states are IDLE, ISSUE, WAIT and ACK; every transition occurs on posedge Clk.
REQ-018 IDLE: if any ReqN is high, register the winner's Ad, WrData and We into Ad/WrData/MemWr, set Owner, and go to ISSUE; otherwise stay in IDLE with MemWr=0.
REQ-019 ISSUE: memory outputs are held stable for the memory's sampling edge; next state is WAIT.
REQ-020 WAIT: MemWr is driven 0; at the exiting edge, DM is captured into RdData[Owner] for reads only, AckOwner is set, and the next state is ACK.
REQ-021 ACK: AckOwner is high for exactly this cycle; ReqN is not sampled; next state is IDLE.
REQ-022 Latency is fixed: a request seen in IDLE in cycle t yields Ack in cycle t+3; peak throughput is one access per 4 cycles.
REQ-023 Arbitration is round-robin: if only one port requests, that port wins; if both request, the port not equal to Last wins; Last is updated to the winner on every grant.
REQ-024 Request inputs are sampled only in IDLE; changes to AdN, WeN or WrDataN after the grant have no effect on the transaction in flight.
REQ-025 If ReqN drops before AckN, the transaction is not aborted and AckN still pulses.
REQ-026 A requester may keep ReqN high after AckN with new Ad/We/WrData; this is treated as a new request in the following IDLE cycle.
REQ-027 A write never modifies RdDataN.
REQ-028 Ack0 and Ack1 are never high in the same cycle.

Reset
REQ-029 While Reset=0: state=IDLE, MemWr=0, Ad=0, WrData=0, Ack0=Ack1=0, RdData0=RdData1=0, Owner=0, Last=1 (port 0 wins the first tie), Busy=0.
REQ-030 Reset asserted mid-transaction abandons the transaction with no Ack; MemWr falls asynchronously.

Structure
REQ-031 Shared package dm_arb_pkg holds the state enum (IDLE, ISSUE, WAIT, ACK) and the AW/DW defaults.
REQ-032 The 2-way round-robin pick (Req0, Req1, Last -> winner) is sub-module rr_arb2; the FSM and registers live in dm_arbiter.

Verification
REQ-033 Single read: Req0=1, We0=0, Ad0=0x04, memory word 4=0xDEADBEEF -> Ack0 in cycle t+3, RdData0=0xDEADBEEF, MemWr never high.
REQ-034 Write then read: port 1 writes 0x12345678 to Ad=0x10, then reads 0x10 -> MemWr high only in ISSUE/grant window, second Ack1 returns 0x12345678.
REQ-035 Contention: Req0 and Req1 high together after reset, held for 3 transactions each -> grants alternate 0,1,0,1,0,1; Ack0 and Ack1 never overlap.
REQ-036 Early drop: Req1 pulsed for 1 cycle in IDLE -> Ack1 still issued 3 cycles later; no second transaction starts.
REQ-037 Reset mid-op: Reset=0 during WAIT of a port-0 read -> Ack0 never pulses, all outputs at reset values, the next tie grants port 0.
